// File: rtl/pixel_scan_sequencer_pkg.sv
// Shared defaults and the pixel tag record carried alongside generated rays.
// Multisampling is compiled in only with PIXEL_SCAN_MULTISAMPLE_EN.
package pixel_scan_sequencer_pkg;
  localparam int H_RES_DEF = 800;
  localparam int V_RES_DEF = 600;
  localparam int SPP_DEF   = 4;
  localparam int COORD_W   = 10;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               last_sample;
    logic               valid;
  } pixel_tag_t;
endpackage

// File: rtl/pixel_scan_sequencer_tag_delay_line.sv
// Stall-gated shift register aligning pixel tags with the ray generator output.
// Behaviour is independent of PIXEL_SCAN_MULTISAMPLE_EN.
module tag_delay_line
  import pixel_scan_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  pixel_tag_t tag_in,
  output pixel_tag_t tag_out
);
  pixel_tag_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else if (!stall) begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];
endmodule

// File: rtl/pixel_scan_sequencer.sv
// Raster pixel/sample issue sequencer with a ray-aligned tag delay line.
// Define PIXEL_SCAN_MULTISAMPLE_EN to issue SPP samples per pixel.
module pixel_scan_sequencer
  import pixel_scan_sequencer_pkg::*;
#(
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF,
  parameter int SPP         = SPP_DEF,
  parameter int RAY_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_valid,
  output logic [9:0] tag_x,
  output logic [9:0] tag_y,
  output logic       tag_valid,
  output logic       tag_last_sample,
  output logic       busy,
  output logic       frame_done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

`ifdef PIXEL_SCAN_MULTISAMPLE_EN
  localparam int SPP_EFF = SPP;
`else
  // Single-sample build: the sample counter degenerates to a constant 0.
  localparam int SPP_EFF = (SPP > 0) ? 1 : 1;
`endif
  localparam int SW = (SPP_EFF > 1) ? $clog2(SPP_EFF) : 1;
  localparam int DW = $clog2(RAY_LATENCY + 1);

  logic [1:0]    state;
  logic [SW-1:0] sample;
  logic [DW-1:0] drain_cnt;
  logic          last_s, last_x, last_y, drain_end;
  pixel_tag_t    tag_in, tag_out;

  assign last_s    = sample == SW'(SPP_EFF - 1);
  assign last_x    = pixel_x == 10'(H_RES - 1);
  assign last_y    = pixel_y == 10'(V_RES - 1);
  assign drain_end = drain_cnt == DW'(RAY_LATENCY - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pixel_x   <= '0;
      pixel_y   <= '0;
      sample    <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= SCAN;
        SCAN: if (!stall) begin
          if (last_s) begin
            sample <= '0;
            if (last_x) begin
              pixel_x <= '0;
              if (last_y) begin
                pixel_y   <= '0;
                drain_cnt <= '0;
                state     <= DRAIN;
              end else begin
                pixel_y <= pixel_y + 10'd1;
              end
            end else begin
              pixel_x <= pixel_x + 10'd1;
            end
          end else begin
            sample <= sample + SW'(1);
          end
        end
        DRAIN: if (!stall) begin
          if (drain_end) state <= IDLE;
          else           drain_cnt <= drain_cnt + DW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bubbles enter the line as all-zero tags so invalid tag outputs read 0.
  always_comb begin
    tag_in = '0;
    if (state == SCAN) begin
      tag_in.x           = pixel_x;
      tag_in.y           = pixel_y;
      tag_in.last_sample = last_s;
      tag_in.valid       = 1'b1;
    end
  end

  tag_delay_line #(.DEPTH(RAY_LATENCY)) u_tag_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stall),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign pixel_valid     = state == SCAN;
  assign busy            = state != IDLE;
  assign frame_done      = (state == DRAIN) && !stall && drain_end;
  assign tag_x           = tag_out.x;
  assign tag_y           = tag_out.y;
  assign tag_valid       = tag_out.valid;
  assign tag_last_sample = tag_out.last_sample;
endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Directed bench for pixel_scan_sequencer on a reduced 16x8 raster.
// Expected sample count follows PIXEL_SCAN_MULTISAMPLE_EN when defined globally.
module tb_pixel_scan_sequencer;
  localparam int H   = 16;
  localparam int V   = 8;
  localparam int LAT = 4;
`ifdef PIXEL_SCAN_MULTISAMPLE_EN
  localparam int SPPE = 4;
`else
  localparam int SPPE = 1;
`endif
  localparam int TOTAL = H * V * SPPE;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
  logic [9:0] pixel_x, pixel_y, tag_x, tag_y;
  logic       pixel_valid, tag_valid, tag_last_sample, busy, frame_done;

  int tests = 0, fails = 0;

  pixel_scan_sequencer #(.H_RES(H), .V_RES(V), .SPP(4), .RAY_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .tag_x(tag_x), .tag_y(tag_y), .tag_valid(tag_valid),
    .tag_last_sample(tag_last_sample), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue index k -> {x, y, last_sample, valid}; negative index is a bubble.
  function automatic logic [21:0] tag_of(input int k);
    int p;
    if (k < 0) return '0;
    p = k / SPPE;
    return {10'(p % H), 10'(p / H), (k % SPPE) == SPPE - 1, 1'b1};
  endfunction

  function automatic logic [21:0] tag_now();
    return {tag_x, tag_y, tag_last_sample, tag_valid};
  endfunction

  typedef struct {
    bit start;
    bit stall;
    int pk;    // expected issued sample index, -1 = no pixel_valid
    int tk;    // expected tag sample index, -1 = bubble
    bit busy;
  } vec_t;

  // Whole frame against a reference: tag equals the issue seen LAT unstalled cycles back.
  task automatic run_frame(input int stall_k, input int stall_len, input int start_k,
                           input int drain_stall);
    int k = 0, nsf = 0, m, st = 0, dst = 0;
    int hist[$];
    bit active = 0, done = 0, pv_exp, done_exp;
    logic [21:0] t;
    for (int cyc = 0; cyc < TOTAL + 200 && !done; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0) || (active && k == start_k);
      stall = 1'b0;
      if (active && k == stall_k && st < stall_len) begin stall = 1'b1; st++; end
      if (active && k == TOTAL && nsf == 1 && dst < drain_stall) begin stall = 1'b1; dst++; end
      @(negedge clk);
      pv_exp = active && k < TOTAL;
      chk("pixel_valid", pixel_valid, pv_exp);
      if (pv_exp) begin
        t = tag_of(k);
        chk("pixel_xy", {pixel_x, pixel_y}, t[21:2]);
      end
      m = hist.size();
      chk("tag", tag_now(), tag_of(m >= LAT ? hist[m-LAT] : -1));
      chk("busy", busy, active);
      done_exp = active && k == TOTAL && !stall && nsf == LAT - 1;
      chk("frame_done", frame_done, done_exp);
      if (!stall) begin
        hist.push_back(pv_exp ? k : -1);
        if (active && k == TOTAL) nsf++;
        if (pv_exp) k++;
      end
      if (done_exp) begin done = 1; active = 0; end
      if (cyc == 0) active = 1;
    end
    chk("frame_completed", done, 1);
    chk("issue_count", k, TOTAL);
    @(posedge clk); #1 start = 0; stall = 0;
    @(negedge clk);
    chk("idle_after_done", {busy, pixel_valid, frame_done, tag_valid}, 0);
  endtask

  vec_t vt[13];

  initial begin
    vt[0]  = '{0, 0, -1, -1, 0};
    vt[1]  = '{0, 1, -1, -1, 0};
    vt[2]  = '{1, 0, -1, -1, 0};
    vt[3]  = '{0, 0,  0, -1, 1};
    vt[4]  = '{0, 0,  1, -1, 1};
    vt[5]  = '{1, 0,  2, -1, 1};
    vt[6]  = '{0, 0,  3, -1, 1};
    vt[7]  = '{0, 0,  4,  0, 1};
    vt[8]  = '{0, 1,  5,  1, 1};
    vt[9]  = '{0, 1,  5,  1, 1};
    vt[10] = '{0, 0,  5,  1, 1};
    vt[11] = '{0, 0,  6,  2, 1};
    vt[12] = '{0, 0,  7,  3, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pix", {pixel_x, pixel_y, pixel_valid, busy, frame_done}, 0);
    chk("reset_tag", tag_now(), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      logic [21:0] t;
      @(posedge clk); #1;
      start = vt[i].start;
      stall = vt[i].stall;
      @(negedge clk);
      chk("vec_pv", pixel_valid, vt[i].pk >= 0);
      if (vt[i].pk >= 0) begin
        t = tag_of(vt[i].pk);
        chk("vec_xy", {pixel_x, pixel_y}, t[21:2]);
      end
      chk("vec_tag", tag_now(), tag_of(vt[i].tk));
      chk("vec_busy", busy, vt[i].busy);
      chk("vec_done", frame_done, 0);
    end

    // Reset mid-frame: outputs clear immediately and the frame never completes.
    @(posedge clk); #1 rst_n = 1'b0; start = 0; stall = 0;
    #1;
    chk("midrst_pix", {pixel_x, pixel_y, pixel_valid, busy, frame_done}, 0);
    chk("midrst_tag", tag_now(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_quiet", {busy, pixel_valid, frame_done, tag_valid}, 0);
    end

    run_frame(-1, 0, -1, 0);
    // Stall 3 cycles at (10,5), spurious start during SCAN, stall inside drain.
    run_frame((5 * H + 10) * SPPE, 3, 20, 2);
    // Row wrap region with a stall on the last sample of (H-1,0).
    run_frame(H * SPPE - 1, 2, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
